// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, hold/flush/redirect controls out.
// The controller uses the slave modport; the pipeline side uses master.
interface hazard_ctrl_if #(
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned PERF_W     = 32
);
    logic                         ex_valid_i;
    logic [6:0]                   ex_opcode_i;
    logic [REG_ADDR_W-1:0]        ex_waddr_i;
    logic                         jump_flag_i;
    logic [ADDR_W-1:0]            jump_addr_i;
    logic                         div_start_i;
    logic                         id_valid_i;
    logic [NUM_RD*REG_ADDR_W-1:0] id_raddr_i;
    logic [NUM_RD-1:0]            id_rden_i;
    logic                         ext_hold_i;

    logic                         pc_hold_o;
    logic                         if_id_hold_o;
    logic                         id_ex_hold_o;
    logic                         if_id_flush_o;
    logic                         id_ex_flush_o;
    logic                         pc_jump_o;
    logic [ADDR_W-1:0]            pc_jump_addr_o;
    logic                         div_kill_o;
    logic [PERF_W-1:0]            stall_cnt_o;

    modport master (
        output ex_valid_i, ex_opcode_i, ex_waddr_i, jump_flag_i, jump_addr_i,
               div_start_i, id_valid_i, id_raddr_i, id_rden_i, ext_hold_i,
        input  pc_hold_o, if_id_hold_o, id_ex_hold_o, if_id_flush_o, id_ex_flush_o,
               pc_jump_o, pc_jump_addr_o, div_kill_o, stall_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_opcode_i, ex_waddr_i, jump_flag_i, jump_addr_i,
               div_start_i, id_valid_i, id_raddr_i, id_rden_i, ext_hold_i,
        output pc_hold_o, if_id_hold_o, id_ex_hold_o, if_id_flush_o, id_ex_flush_o,
               pc_jump_o, pc_jump_addr_o, div_kill_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/redirect controller: load-use and divide stalls, jump redirect
// with multi-cycle fetch flush, external hold, and a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned DIV_LAT    = 32,
    parameter int unsigned FLUSH_CYC  = 1,
    parameter int unsigned PERF_W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    localparam logic [6:0]  INST_TYPE_L = 7'b0000011;
    localparam int unsigned MAX_A       = (LOAD_LAT > DIV_LAT) ? LOAD_LAT : DIV_LAT;
    localparam int unsigned MAX_LAT     = (MAX_A > FLUSH_CYC) ? MAX_A : FLUSH_CYC;
    localparam int unsigned CNT_W       = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] FL_INIT  = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {StIdle, StLdStall, StDivBusy, StFlush} state_e;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    logic              w_match;
    logic              w_load_use;
    logic              w_pc_hold;
    logic              w_if_id_hold;
    logic              w_id_ex_hold;
    logic              w_if_id_flush;
    logic              w_id_ex_flush;
    logic              w_pc_jump;
    logic              w_div_kill;
    logic [ADDR_W-1:0] w_jump_addr;

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (bus.id_rden_i[i] &&
                bus.id_raddr_i[i*REG_ADDR_W +: REG_ADDR_W] == bus.ex_waddr_i) begin
                w_match = 1'b1;
            end
        end
        // x0 is hardwired, so a load targeting it can never feed a consumer
        w_load_use = w_match && bus.ex_valid_i && bus.id_valid_i &&
                     (bus.ex_opcode_i == INST_TYPE_L) && (bus.ex_waddr_i != '0);
    end

    always_comb begin
        w_pc_hold     = 1'b0;
        w_if_id_hold  = 1'b0;
        w_id_ex_hold  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_pc_jump     = 1'b0;
        w_div_kill    = 1'b0;
        if (bus.ext_hold_i) begin
            w_pc_hold    = 1'b1;
            w_if_id_hold = 1'b1;
            w_id_ex_hold = 1'b1;
        end else if (bus.jump_flag_i) begin
            w_pc_jump     = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_div_kill    = (r_state == StDivBusy);
        end else begin
            unique case (r_state)
                StDivBusy: begin
                    w_pc_hold    = 1'b1;
                    w_if_id_hold = 1'b1;
                    w_id_ex_hold = 1'b1;
                end
                StLdStall: begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
                StFlush: w_if_id_flush = 1'b1;
                default: begin
                    // a divide issuing from EX cannot also be the load
                    if (!bus.div_start_i && w_load_use) begin
                        w_pc_hold     = 1'b1;
                        w_if_id_hold  = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pc_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
            if (!bus.ext_hold_i) begin
                if (bus.jump_flag_i) begin
                    if (FLUSH_CYC > 1) begin
                        r_state <= StFlush;
                        r_cnt   <= FL_INIT;
                    end else begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end
                end else if (r_state == StIdle) begin
                    if (bus.div_start_i) begin
                        r_state <= StDivBusy;
                        r_cnt   <= DIV_INIT;
                    end else if (w_load_use && (LOAD_LAT > 1)) begin
                        r_state <= StLdStall;
                        r_cnt   <= LD_INIT;
                    end
                end else if (r_cnt <= CNT_W'(1)) begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign w_jump_addr        = bus.jump_addr_i;
    assign bus.pc_hold_o      = w_pc_hold;
    assign bus.if_id_hold_o   = w_if_id_hold;
    assign bus.id_ex_hold_o   = w_id_ex_hold;
    assign bus.if_id_flush_o  = w_if_id_flush;
    assign bus.id_ex_flush_o  = w_id_ex_flush;
    assign bus.pc_jump_o      = w_pc_jump;
    assign bus.pc_jump_addr_o = w_jump_addr;
    assign bus.div_kill_o     = w_div_kill;
    assign bus.stall_cnt_o    = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations share one stimulus stream and are
// compared each cycle against a remaining-cycles reference model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ex_valid, jump_flag, div_start, id_valid, ext_hold;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_waddr;
    logic [31:0] jump_addr;
    logic [9:0]  id_raddr;
    logic [1:0]  id_rden;

    hazard_ctrl_if #(.NUM_RD(2), .REG_ADDR_W(5), .ADDR_W(32), .PERF_W(32)) ifa ();
    hazard_ctrl_if #(.NUM_RD(2), .REG_ADDR_W(5), .ADDR_W(32), .PERF_W(3))  ifb ();

    // A: LOAD_LAT=1, DIV_LAT=32, FLUSH_CYC=1;  B: LOAD_LAT=3, DIV_LAT=4, FLUSH_CYC=3, PERF_W=3
    hazard_ctrl #(.NUM_RD(2), .REG_ADDR_W(5), .ADDR_W(32), .LOAD_LAT(1), .DIV_LAT(32),
                  .FLUSH_CYC(1), .PERF_W(32)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    hazard_ctrl #(.NUM_RD(2), .REG_ADDR_W(5), .ADDR_W(32), .LOAD_LAT(3), .DIV_LAT(4),
                  .FLUSH_CYC(3), .PERF_W(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifa.ex_valid_i  = ex_valid;   assign ifb.ex_valid_i  = ex_valid;
    assign ifa.ex_opcode_i = ex_opcode;  assign ifb.ex_opcode_i = ex_opcode;
    assign ifa.ex_waddr_i  = ex_waddr;   assign ifb.ex_waddr_i  = ex_waddr;
    assign ifa.jump_flag_i = jump_flag;  assign ifb.jump_flag_i = jump_flag;
    assign ifa.jump_addr_i = jump_addr;  assign ifb.jump_addr_i = jump_addr;
    assign ifa.div_start_i = div_start;  assign ifb.div_start_i = div_start;
    assign ifa.id_valid_i  = id_valid;   assign ifb.id_valid_i  = id_valid;
    assign ifa.id_raddr_i  = id_raddr;   assign ifb.id_raddr_i  = id_raddr;
    assign ifa.id_rden_i   = id_rden;    assign ifb.id_rden_i   = id_rden;
    assign ifa.ext_hold_i  = ext_hold;   assign ifb.ext_hold_i  = ext_hold;

    // flags: {pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, pc_jump, div_kill}
    logic [6:0]  flags_o [2];
    logic [31:0] addr_o  [2];
    logic [31:0] scnt_o  [2];
    assign flags_o[0] = {ifa.pc_hold_o, ifa.if_id_hold_o, ifa.id_ex_hold_o, ifa.if_id_flush_o,
                         ifa.id_ex_flush_o, ifa.pc_jump_o, ifa.div_kill_o};
    assign flags_o[1] = {ifb.pc_hold_o, ifb.if_id_hold_o, ifb.id_ex_hold_o, ifb.if_id_flush_o,
                         ifb.id_ex_flush_o, ifb.pc_jump_o, ifb.div_kill_o};
    assign addr_o[0]  = ifa.pc_jump_addr_o;
    assign addr_o[1]  = ifb.pc_jump_addr_o;
    assign scnt_o[0]  = ifa.stall_cnt_o;
    assign scnt_o[1]  = 32'(ifb.stall_cnt_o);

    localparam logic [6:0] F_NONE  = 7'b0000000;
    localparam logic [6:0] F_HOLD  = 7'b1110000;
    localparam logic [6:0] F_LOAD  = 7'b1100100;
    localparam logic [6:0] F_FLUSH = 7'b0001000;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [6:0] last_flags [2];

    // Reference model: cycles still owed to each kind of event, per configuration.
    int     ld_rem  [2];
    int     div_rem [2];
    int     fl_rem  [2];
    longint stalls  [2];

    function automatic int ll(int d);   return (d == 0) ? 1 : 3;  endfunction
    function automatic int dl(int d);   return (d == 0) ? 32 : 4; endfunction
    function automatic int fc(int d);   return (d == 0) ? 1 : 3;  endfunction
    function automatic longint smax(int d); return (d == 0) ? 64'hFFFF_FFFF : 7; endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ld_rem[d] = 0; div_rem[d] = 0; fl_rem[d] = 0; stalls[d] = 0;
        end
    endtask

    task automatic model_eval(int d, output logic [6:0] e);
        bit hz;
        hz = 1'b0;
        for (int i = 0; i < 2; i++)
            if (id_rden[i] && id_raddr[i*5 +: 5] == ex_waddr) hz = 1'b1;
        hz = hz && ex_valid && id_valid && (ex_opcode == 7'h03) && (ex_waddr != 5'd0);
        e = F_NONE;
        if (ext_hold) begin
            e = F_HOLD;
        end else if (jump_flag) begin
            e = {4'b0001, 1'b1, 1'b1, (div_rem[d] > 0)};
            ld_rem[d] = 0; div_rem[d] = 0; fl_rem[d] = fc(d) - 1;
        end else if (div_rem[d] > 0) begin
            e = F_HOLD; div_rem[d]--;
        end else if (ld_rem[d] > 0) begin
            e = F_LOAD; ld_rem[d]--;
        end else if (fl_rem[d] > 0) begin
            e = F_FLUSH; fl_rem[d]--;
        end else if (div_start) begin
            div_rem[d] = dl(d) - 1;
        end else if (hz) begin
            e = F_LOAD; ld_rem[d] = ll(d) - 1;
        end
        if (e[6] && stalls[d] < smax(d)) stalls[d]++;
    endtask

    // Inputs are applied at posedge+1; outputs are checked at posedge+2.
    task automatic cycle();
        logic [6:0] e;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("stall_cnt%0d", d), 64'(scnt_o[d]), 64'(stalls[d]));
            model_eval(d, e);
            last_flags[d] = flags_o[d];
            check($sformatf("flags%0d", d), 64'(flags_o[d]), 64'(e));
            check($sformatf("jaddr%0d", d), 64'(addr_o[d]), 64'(jump_addr));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        ex_valid = 0; ex_opcode = 7'h13; ex_waddr = 0; jump_flag = 0; div_start = 0;
        id_valid = 0; id_raddr = 0; id_rden = 0; ext_hold = 0;
    endtask

    task automatic set_load(logic [4:0] rd, logic [9:0] ra, logic [1:0] en);
        ex_valid = 1; ex_opcode = 7'h03; ex_waddr = rd; id_valid = 1; id_raddr = ra; id_rden = en;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 0; set_idle(); jump_addr = 32'h0000_1234;
        #1;
        check("rst_flags_a", 64'(flags_o[0]), 64'(F_NONE));
        check("rst_flags_b", 64'(flags_o[1]), 64'(F_NONE));
        check("rst_addr_a", 64'(addr_o[0]), 64'h1234);
        check("rst_scnt_b", 64'(scnt_o[1]), 64'd0);
        @(posedge clk); #1; rst_n = 1;

        // Load to x5, consumer on port 1; EX becomes a bubble afterwards.
        set_load(5'd5, {5'd5, 5'd2}, 2'b10);
        cycle();
        check("ld1_a", 64'(last_flags[0]), 64'(F_LOAD));
        check("ld1_b", 64'(last_flags[1]), 64'(F_LOAD));
        ex_valid = 0;
        cycle();
        check("ld1_a_done", 64'(last_flags[0]), 64'(F_NONE));
        check("ld3_b_2", 64'(last_flags[1]), 64'(F_LOAD));
        cycle();
        check("ld3_b_3", 64'(last_flags[1]), 64'(F_LOAD));
        cycle();
        check("ld3_b_done", 64'(last_flags[1]), 64'(F_NONE));
        check("scnt_a_ld", 64'(scnt_o[0]), 64'd1);
        check("scnt_b_ld", 64'(scnt_o[1]), 64'd3);

        // Same pattern targeting x0 never stalls.
        set_load(5'd0, {5'd0, 5'd0}, 2'b11);
        cycle();
        check("x0_a", 64'(last_flags[0]), 64'(F_NONE));
        check("x0_b", 64'(last_flags[1]), 64'(F_NONE));
        set_idle();
        cycle();

        // Divide, then jump to 0x80 on the second hold cycle.
        div_start = 1;
        cycle();
        check("div_start_b", 64'(last_flags[1]), 64'(F_NONE));
        div_start = 0;
        cycle();
        check("div_hold_b", 64'(last_flags[1]), 64'(F_HOLD));
        jump_flag = 1; jump_addr = 32'h80;
        cycle();
        check("div_kill_a", 64'(last_flags[0]), 64'b0001111);
        check("div_kill_b", 64'(last_flags[1]), 64'b0001111);
        jump_flag = 0;
        cycle();
        check("flush1_b", 64'(last_flags[1]), 64'(F_FLUSH));
        check("flush1_a", 64'(last_flags[0]), 64'(F_NONE));
        cycle();
        check("flush2_b", 64'(last_flags[1]), 64'(F_FLUSH));
        cycle();

        // Jump to 0x100 coinciding with a load-use hazard.
        set_load(5'd9, {5'd1, 5'd9}, 2'b01);
        jump_flag = 1; jump_addr = 32'h100;
        cycle();
        check("jmp_ld_a", 64'(last_flags[0]), 64'b0001110);
        check("jmp_ld_b", 64'(last_flags[1]), 64'b0001110);
        set_idle();
        cycle();
        check("jmp_fl1_b", 64'(last_flags[1]), 64'(F_FLUSH));
        cycle();
        check("jmp_fl2_b", 64'(last_flags[1]), 64'(F_FLUSH));
        cycle();
        check("jmp_end_b", 64'(last_flags[1]), 64'(F_NONE));

        // External hold freezes B's load stall for five cycles.
        set_load(5'd7, {5'd3, 5'd7}, 2'b01);
        cycle();
        ex_valid = 0; ext_hold = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("ext_hold_b", 64'(last_flags[1]), 64'(F_HOLD));
        end
        ext_hold = 0;
        cycle();
        check("post_hold1_b", 64'(last_flags[1]), 64'(F_LOAD));
        cycle();
        check("post_hold2_b", 64'(last_flags[1]), 64'(F_LOAD));
        cycle();
        check("post_hold_end_b", 64'(last_flags[1]), 64'(F_NONE));
        check("scnt_b_sat", 64'(scnt_o[1]), 64'd7);

        // Asynchronous reset while A is in its divide with ten cycles left.
        set_idle();
        div_start = 1;
        cycle();
        div_start = 0;
        for (int k = 0; k < 21; k++) cycle();
        #1;
        check("div_pre_rst_a", 64'(flags_o[0]), 64'(F_HOLD));
        rst_n = 0;
        #1;
        check("async_rst_flags_a", 64'(flags_o[0]), 64'(F_NONE));
        check("async_rst_scnt_a", 64'(scnt_o[0]), 64'd0);
        check("async_rst_scnt_b", 64'(scnt_o[1]), 64'd0);
        model_reset();
        @(posedge clk); #1; rst_n = 1;

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_opcode = $urandom_range(0, 1) ? 7'h03 : 7'($urandom);
            ex_waddr  = 5'($urandom_range(0, 7));
            id_valid  = ($urandom_range(0, 3) != 0);
            id_raddr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_rden   = 2'($urandom);
            jump_flag = ($urandom_range(0, 9) == 0);
            jump_addr = $urandom;
            div_start = ($urandom_range(0, 19) == 0);
            ext_hold  = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
